// File: rtl/lsu_msinc_master.sv
// lsu_msinc_master -- load/store initiator from the MEM stage to a word-wide
// memory. The memory has a synchronous write port and an asynchronous read port.
//
// Accepts one byte-addressed load or store per req/ready handshake. Load data
// is returned aligned and extended on a 1-cycle rvalid pulse. The memory only
// writes whole 32-bit words, so sub-word stores are done as read-modify-write.
//
// Build option: define LSU_SUBWORD_EN to enable byte/half accesses. When it is
// undefined, only word accesses are legal and the lane shifter and merge
// logic are not built.
//
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   req_i             request, accepted when req_i && ready_o
//   we_i              1 = store, 0 = load
//   size_i            00 byte, 01 half, 10 word, 11 illegal
//   sext_i            loads: 1 = sign-extend, 0 = zero-extend
//   addr_i            byte address; [1:0] lane, [ADDR_W+1:2] word index
//   wdata_i           store data, right-aligned
//   ready_o           idle, can accept
//   rvalid_o, rdata_o load result pulse / data (rdata_o holds between loads)
//   err_o             misaligned/illegal request pulse
//   mem_we_o, mem_addr_r_o, mem_addr_w_o, mem_data_w_o   memory write/read pins
//   mem_data_r_i      memory read data (combinational from mem_addr_r_o)

// A single byte lane of the RMW merge: take the new byte when the lane is
// enabled, otherwise keep the byte read from memory.
module lsu_msinc_lane (
  input  logic       en,
  input  logic [7:0] oldByte,
  input  logic [7:0] newByte,
  output logic [7:0] outByte
);
  assign outByte = en ? newByte : oldByte;
endmodule

module lsu_msinc_master #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [ADDR_W+1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_r_o,
  output logic [ADDR_W-1:0] mem_addr_w_o,
  output logic [31:0]       mem_data_w_o,
  input  logic [31:0]       mem_data_r_i
);

  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, ERR} state_t;

  state_t            state, stateNxt;
  logic              accept, legal;
  logic [ADDR_W-1:0] idxQ;
  logic [31:0]       dataWQ;
  logic [31:0]       rdataQ;
  logic              rvalidQ;
  logic [31:0]       loadVal;

  assign accept = req_i && (state == IDLE);

  // ---------------------------------------------------------------------------
  // Alignment / size legality, evaluated on the live request in IDLE
  // ---------------------------------------------------------------------------
`ifdef LSU_SUBWORD_EN
  assign legal = (size_i == 2'b00) ||
                 (size_i == 2'b01 && !addr_i[0]) ||
                 (size_i == 2'b10 && addr_i[1:0] == 2'b00);
`else
  logic unusedSext;
  assign unusedSext = sext_i;
  assign legal = (size_i == 2'b10) && (addr_i[1:0] == 2'b00);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt = IDLE;
    case (state)
      IDLE: begin
        stateNxt = IDLE;
        if (req_i) begin
          if (!legal)                  stateNxt = ERR;
          else if (!we_i)              stateNxt = LOAD;
          else if (size_i == 2'b10)    stateNxt = WRITE;
          else                         stateNxt = RMW_RD;
        end
      end
      LOAD:    stateNxt = IDLE;
      RMW_RD:  stateNxt = WRITE;
      WRITE:   stateNxt = IDLE;
      ERR:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction and sub-word merge
  // ---------------------------------------------------------------------------
`ifdef LSU_SUBWORD_EN
  logic [1:0]                  sizeQ;
  logic                        sextQ;
  logic [1:0]                  laneQ;
  logic [31:0]                 shifted;
  logic [NUM_LANES-1:0]        byteEn;
  logic [NUM_LANES-1:0][7:0]   oldBytes, newBytes, mergedBytes;

  assign shifted = mem_data_r_i >> {laneQ, 3'b000};

  always_comb begin
    case (sizeQ)
      2'b00:   loadVal = {{24{sextQ & shifted[7]}},  shifted[7:0]};
      2'b01:   loadVal = {{16{sextQ & shifted[15]}}, shifted[15:0]};
      default: loadVal = mem_data_r_i;
    endcase
  end

  // Store data is replicated across the word so each lane picks its own byte.
  assign byteEn   = (sizeQ == 2'b00) ? (4'b0001 << laneQ) : (4'b0011 << laneQ);
  assign newBytes = (sizeQ == 2'b00) ? {4{dataWQ[7:0]}} : {2{dataWQ[15:0]}};
  assign oldBytes = mem_data_r_i;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    lsu_msinc_lane uLane (
      .en      (byteEn[g]),
      .oldByte (oldBytes[g]),
      .newByte (newBytes[g]),
      .outByte (mergedBytes[g])
    );
  end
`else
  assign loadVal = mem_data_r_i;
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idxQ    <= '0;
      dataWQ  <= '0;
      rdataQ  <= '0;
      rvalidQ <= 1'b0;
`ifdef LSU_SUBWORD_EN
      sizeQ   <= '0;
      sextQ   <= 1'b0;
      laneQ   <= '0;
`endif
    end else begin
      // rvalid follows LOAD by one cycle, so it lands in the ready cycle.
      rvalidQ <= (state == LOAD);
      if (accept) begin
        idxQ <= addr_i[ADDR_W+1:2];
        if (we_i && legal) dataWQ <= wdata_i;
`ifdef LSU_SUBWORD_EN
        sizeQ <= size_i;
        sextQ <= sext_i;
        laneQ <= addr_i[1:0];
`endif
      end
      if (state == LOAD) rdataQ <= loadVal;
`ifdef LSU_SUBWORD_EN
      // Merged word replaces the store data; WRITE then puts it on the pins.
      if (state == RMW_RD) dataWQ <= mergedBytes;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers or pure state decode, nothing combinational from req_i
  // ---------------------------------------------------------------------------
  assign ready_o      = (state == IDLE);
  assign err_o        = (state == ERR);
  assign mem_we_o     = (state == WRITE);
  assign rvalid_o     = rvalidQ;
  assign rdata_o      = rdataQ;
  assign mem_addr_r_o = idxQ;
  assign mem_addr_w_o = idxQ;
  assign mem_data_w_o = dataWQ;

endmodule

// File: tb/tb_lsu_msinc_master.sv
// Testbench for lsu_msinc_master: a table of directed vectors, hand-written
// reset and back-to-back sequences, and randomized transactions checked
// against a byte-level reference model of the memory.
module tb_lsu_msinc_master;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
`ifdef LSU_SUBWORD_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i, we_i, sext_i;
  logic [1:0]    size_i;
  logic [AW+1:0] addr_i;
  logic [31:0]   wdata_i;
  logic          ready_o, rvalid_o, err_o, mem_we_o;
  logic [31:0]   rdata_o, mem_data_w_o, mem_data_r_i;
  logic [AW-1:0] mem_addr_r_o, mem_addr_w_o;

  lsu_msinc_master #(.ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .size_i(size_i), .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_we_o(mem_we_o), .mem_addr_r_o(mem_addr_r_o), .mem_addr_w_o(mem_addr_w_o),
    .mem_data_w_o(mem_data_w_o), .mem_data_r_i(mem_data_r_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory attached to the DUT, plus a backdoor preload port.
  bit [31:0]     mem    [0:DEPTH-1];
  bit [31:0]     refMem [0:DEPTH-1];
  logic          preEn = 1'b0;
  logic [AW-1:0] preIdx = '0;
  logic [31:0]   preVal = '0;

  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_w_o] <= mem_data_w_o;
    if (preEn)    mem[preIdx]       <= preVal;
  end
  assign mem_data_r_i = mem[mem_addr_r_o];

  int          nVec = 0;
  int          nErr = 0;
  int          weTotal = 0;
  logic [31:0] lastRd = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic bit refLegal(logic [1:0] size, logic [1:0] lane);
`ifdef LSU_SUBWORD_EN
    return (size == 2'd0) || (size == 2'd1 && lane[0] == 1'b0) ||
           (size == 2'd2 && lane == 2'd0);
`else
    return (size == 2'd2) && (lane == 2'd0);
`endif
  endfunction

  function automatic logic [31:0] byteMask(int n);
    if (n >= 4) return 32'hFFFF_FFFF;
    return (32'h1 << (8 * n)) - 32'h1;
  endfunction

  function automatic logic [31:0] refLoad(logic [31:0] w, int lane, logic [1:0] size, logic sext);
    int n = 1 << size;
    logic [31:0] v, m;
    v = w >> (8 * lane);
    m = byteMask(n);
    v = v & m;
    if (sext && n < 4 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] refStore(logic [31:0] w, int lane, logic [1:0] size, logic [31:0] d);
    int n = 1 << size;
    for (int i = 0; i < n; i++)
      if (lane + i < 4) w[8*(lane+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  // ---------------- drivers ----------------
  task automatic preload(input int idx, input logic [31:0] val);
    preEn = 1'b1; preIdx = AW'(idx); preVal = val;
    refMem[idx] = val;
    @(posedge clk_i);
    @(negedge clk_i);
    preEn = 1'b0;
  endtask

  // Issue one transaction (called at a negedge with the DUT idle) and check
  // every cycle until ready returns. req_i stays high with junk while busy.
  task automatic txn(input logic we, input logic [1:0] size, input logic sext,
                     input logic [AW+1:0] addr, input logic [31:0] wdata,
                     output logic gotErr, output logic [31:0] gotRd);
    int idx, lane, expLat, weCnt, errCnt, errAt, rvCnt, rvAt, lat;
    bit lg;
    logic [31:0] expRd, newWord;
    idx     = int'(addr[AW+1:2]);
    lane    = int'(addr[1:0]);
    lg      = refLegal(size, addr[1:0]);
    newWord = refStore(refMem[idx], lane, size, wdata);
    expRd   = refLoad(refMem[idx], lane, size, sext);
    expLat  = (lg && we && size != 2'd2) ? 3 : 2;
    weCnt = 0; errCnt = 0; errAt = 0; rvCnt = 0; rvAt = 0; lat = 0;
    gotRd = '0;
    check("ready_at_req", 32'(ready_o), 32'd1);
    req_i = 1'b1; we_i = we; size_i = size; sext_i = sext; addr_i = addr; wdata_i = wdata;
    @(posedge clk_i);
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk_i);
      if (mem_we_o) begin
        weCnt++;
        check("mem_addr_w", 32'(mem_addr_w_o), 32'(idx));
        check("mem_data_w", mem_data_w_o, newWord);
      end
      if (k == 1 && lg && !(we && size == 2'd2))
        check("mem_addr_r", 32'(mem_addr_r_o), 32'(idx));
      if (err_o) begin errCnt++; errAt = k; end
      if (rvalid_o) begin rvCnt++; rvAt = k; gotRd = rdata_o; end
      if (ready_o) lat = k;
      else begin
        req_i = 1'b1; we_i = 1'($urandom); size_i = 2'($urandom);
        sext_i = 1'($urandom); addr_i = (AW+2)'($urandom); wdata_i = $urandom;
      end
    end
    gotErr = (errCnt != 0);
    check("latency", 32'(lat), 32'(expLat));
    check("we_cycles", 32'(weCnt), (lg && we) ? 32'd1 : 32'd0);
    check("err_pulses", 32'(errCnt), lg ? 32'd0 : 32'd1);
    if (!lg) check("err_cycle", 32'(errAt), 32'd1);
    check("rvalid_pulses", 32'(rvCnt), (lg && !we) ? 32'd1 : 32'd0);
    if (lg && !we) begin
      check("rvalid_cycle", 32'(rvAt), 32'd2);
      check("rdata", gotRd, expRd);
      lastRd = expRd;
    end
    check("rdata_hold", rdata_o, lastRd);
    if (lg && we) refMem[idx] = newWord;
    check("mem_word", mem[idx], refMem[idx]);
    weTotal += weCnt;
    req_i = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          pre;
    logic [31:0] preVal;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRd;
    bit          chkRd;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    logic        e;
    logic [31:0] r;
    int          weBefore, weSeen;

    vecs[0]  = '{0, 32'h0, 1, 2'd2, 0, 14'h010, 32'hDEADBEEF, 0, 32'h0, 0};
    vecs[1]  = '{0, 32'h0, 0, 2'd2, 0, 14'h010, 32'h0, 0, 32'hDEADBEEF, 1};
    vecs[2]  = '{1, 32'h11223344, 1, 2'd0, 0, 14'h012, 32'h123456AB, !SW, 32'h0, 0};
    vecs[3]  = '{0, 32'h0, 0, 2'd2, 0, 14'h010, 32'h0, 0,
                 SW ? 32'h11AB3344 : 32'h11223344, 1};
    vecs[4]  = '{1, 32'h80F07F01, 0, 2'd1, 1, 14'h012, 32'h0, !SW, 32'hFFFF80F0, 1};
    vecs[5]  = '{0, 32'h0, 0, 2'd1, 0, 14'h012, 32'h0, !SW, 32'h000080F0, 1};
    vecs[6]  = '{0, 32'h0, 0, 2'd0, 1, 14'h011, 32'h0, !SW, 32'h0000007F, 1};
    vecs[7]  = '{0, 32'h0, 0, 2'd2, 0, 14'h013, 32'h0, 1, 32'h0, 0};
    vecs[8]  = '{0, 32'h0, 1, 2'd1, 0, 14'h011, 32'hCAFE, 1, 32'h0, 0};
    vecs[9]  = '{0, 32'h0, 0, 2'd2, 0, 14'h010, 32'h0, 0, 32'h80F07F01, 1};
    vecs[10] = '{0, 32'h0, 0, 2'd3, 0, 14'h010, 32'h0, 1, 32'h0, 0};

    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = '0; sext_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    #12;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr_r", 32'(mem_addr_r_o), 32'd0);
    check("rst_addr_w", 32'(mem_addr_w_o), 32'd0);
    check("rst_data_w", mem_data_w_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i <= 10; i++) begin
      if (vecs[i].pre) preload(int'(vecs[i].addr[13:2]), vecs[i].preVal);
      txn(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata, e, r);
      check("tbl_err", 32'(e), 32'(vecs[i].expErr));
      if (vecs[i].chkRd && !vecs[i].expErr) check("tbl_rdata", r, vecs[i].expRd);
    end

    // Back-to-back: two word stores then a load, each issued in the ready cycle.
    weBefore = weTotal;
    txn(1, 2'd2, 0, 14'h020, 32'hA5A5_0001, e, r);
    txn(1, 2'd2, 0, 14'h020, 32'h5A5A_0002, e, r);
    txn(0, 2'd2, 0, 14'h020, 32'h0, e, r);
    check("b2b_writes", 32'(weTotal - weBefore), 32'd2);
    check("b2b_rdata", r, 32'h5A5A_0002);

    // Reset while WRITE is on the pins: mem_we_o drops at once, no write.
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; sext_i = 1'b0;
    addr_i = 14'h040; wdata_i = 32'h5555_AAAA;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rstw_we_before", 32'(mem_we_o), 32'd1);
    req_i = 1'b0; rst_ni = 1'b0;
    #1;
    check("rstw_we_drop", 32'(mem_we_o), 32'd0);
    check("rstw_ready", 32'(ready_o), 32'd1);
    check("rstw_rdata", rdata_o, 32'd0);
    lastRd = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rstw_mem", mem[16], refMem[16]);

`ifdef LSU_SUBWORD_EN
    // Reset during RMW_RD of a byte store: the merged write never happens.
    preload(4, 32'h11223344);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; addr_i = 14'h012; wdata_i = 32'hAB;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rmw_rst_busy", 32'(ready_o), 32'd0);
    req_i = 1'b0; rst_ni = 1'b0;
    #1;
    check("rmw_rst_ready", 32'(ready_o), 32'd1);
    weSeen = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (mem_we_o) weSeen++;
    end
    check("rmw_rst_we", 32'(weSeen), 32'd0);
    check("rmw_rst_mem", mem[4], 32'h11223344);
    check("rmw_rst_ready_after", 32'(ready_o), 32'd1);
`endif

    // Randomized transactions over a small working set, including the top words.
    for (int t = 0; t < 300; t++) begin
      int          idx, lane;
      logic [1:0]  sz;
      logic [AW+1:0] a;
      idx  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7))
                                         : DEPTH - 1 - int'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) sz = 2'd2;
      lane = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) lane = (sz == 2'd1) ? lane & 2 : 0;
      a = {AW'(idx), 2'(lane)};
      txn(1'($urandom), sz, 1'($urandom), a, $urandom, e, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/lsu_msinc_master.md
Name: lsu_msinc_master

Overview:
- Load/store initiator between the MEM stage of the segmented core and the word-wide synchronous-write / asynchronous-read data memory.
- Accepts one byte-addressed load or store per transaction over a req/ready handshake and drives the memory's WE / AddrR / AddrW / DataW pins.
- Returns load data aligned and extended on a 1-cycle rvalid pulse.
- Implements sub-word stores as read-modify-write, because the memory writes whole 32-bit words only.

Parameters:
- ADDR_W, 12, word-index width of the memory (depth 2**ADDR_W words of 32 bits)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  transaction request; accepted when req_i && ready_o
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- sext_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr_i  in  ADDR_W+2  byte address; [1:0] selects lane, [ADDR_W+1:2] is word index
- wdata_i  in  32  store data, right-aligned
- ready_o  out  1  block idle, can accept
- rvalid_o  out  1  load data valid, 1-cycle pulse
- rdata_o  out  32  load result
- err_o  out  1  misaligned/illegal request, 1-cycle pulse
- mem_we_o  out  1  memory write enable
- mem_addr_r_o  out  ADDR_W  memory read index
- mem_addr_w_o  out  ADDR_W  memory write index
- mem_data_w_o  out  32  memory write data
- mem_data_r_i  in  32  memory read data (combinational from mem_addr_r_o)

Behaviour:
- Reset (async, rst_ni = 0): state IDLE; ready_o = 1; rvalid_o = 0; err_o = 0; mem_we_o = 0; rdata_o, mem_addr_*_o, mem_data_w_o = 0.
- All outputs are registered or decoded from state only; no combinational path from req_i to mem_* outputs.
- States: IDLE, LOAD, RMW_RD, WRITE, ERR.
- ready_o = 1 only in IDLE. Inputs are latched on acceptance; later changes are ignored.
- Alignment check at accept:
  - half requires addr[0] = 0; word requires addr[1:0] = 00; size 11 is always illegal.
  - Violation: go to ERR. err_o = 1 for one cycle (N+1), no memory access, then IDLE.
- Load, accepted cycle N: LOAD in N+1 with mem_addr_r_o = word index.
  - mem_data_r_i is shifted by lane*8, truncated to size, extended per sext_i, and registered at end of N+1.
  - rvalid_o = 1 and rdata_o valid in N+2; ready_o = 1 in N+2.
- Word store, accepted cycle N: WRITE in N+1 with mem_we_o = 1, mem_addr_w_o = index, mem_data_w_o = wdata_i. ready_o = 1 in N+2.
- Sub-word store, accepted cycle N:
  - RMW_RD in N+1: read the word and merge wdata_i[7:0] or [15:0] into the addressed lane; other bytes are preserved.
  - WRITE in N+2 writes the merged word. ready_o = 1 in N+3.
- mem_we_o is high only in WRITE. mem_addr_w_o equals mem_addr_r_o during RMW.
- rvalid_o and err_o are never high in the same cycle, and never high for stores.
- rdata_o holds its last value until the next load completes.
- Back-to-back: a request held high in the ready cycle is accepted in that cycle; no bubble beyond the latencies above.
- Reset mid-transaction: the transaction is abandoned and mem_we_o drops immediately. A pending RMW write does not occur.
- Word index wraps modulo 2**ADDR_W; addr bits above ADDR_W+1 do not exist.

Optional Feature:
- Macro: LSU_SUBWORD_EN.
- Defined: byte/half loads and stores behave as above.
- Undefined: only size 10 is legal. Sizes 00/01/11 take the ERR path (err_o pulse, no access). RMW_RD and the lane shifters are not synthesized. Word latencies are unchanged.

Test Plan:
- Word store then load: store addr 0x010, wdata 0xDEADBEEF; load addr 0x010 -> mem_we_o high 1 cycle at index 4; rvalid_o in N+2 with rdata_o = 0xDEADBEEF.
- Byte store RMW: memory[4] = 0x11223344; store byte 0xAB at addr 0x012 -> memory[4] = 0x11AB3344; ready_o low for 2 cycles after accept.
- Sign/zero extension: memory[4] = 0x80F0_7F01. Half load addr 0x012 with sext = 1 -> 0xFFFF80F0; with sext = 0 -> 0x000080F0. Byte load addr 0x011 with sext = 1 -> 0x0000007F.
- Misaligned: word load addr 0x013, and half store addr 0x011 -> err_o pulse in N+1, rvalid_o = 0, mem_we_o never asserted, memory unchanged.
- Reset mid-RMW: assert rst_ni = 0 during RMW_RD of a byte store -> mem_we_o stays 0, memory unchanged, ready_o = 1 after release.
- Back-to-back with req_i held: word store, word store, load -> exactly two write cycles; the load returns the second store's data.
